// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO control shim: state encoding, width defaults
// and the usable-capacity derivation.
package pifo_pkg;

   localparam int DEF_L2_MAX_SIZE = 3;
   localparam int DEF_RANK_WIDTH  = 8;
   localparam int DEF_META_WIDTH  = 8;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_WAIT   = 1'b1
   } pifo_state_e;

   // One slot is kept in reserve so the PIFO's log2-wide entry counter never wraps.
   function automatic int capacity(input int max_size);
      return max_size - 1;
   endfunction

endpackage

// File: rtl/pifo_deq_ctrl.sv
// Control shim around a register-based PIFO: valid/ready enqueue, settle-aware
// dequeue into a registered output stage, never inserting and removing together.
module pifo_deq_ctrl
   import pifo_pkg::*;
#(
   parameter int L2_MAX_SIZE = DEF_L2_MAX_SIZE,
   parameter int MAX_SIZE    = 2**L2_MAX_SIZE,
   parameter int RANK_WIDTH  = DEF_RANK_WIDTH,
   parameter int META_WIDTH  = DEF_META_WIDTH
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [RANK_WIDTH-1:0]  s_rank,
   input  logic [META_WIDTH-1:0]  s_meta,
   output logic                   pif_insert,
   output logic                   pif_remove,
   output logic [RANK_WIDTH-1:0]  pif_rank_in,
   output logic [META_WIDTH-1:0]  pif_meta_in,
   input  logic [RANK_WIDTH-1:0]  pif_rank_out,
   input  logic [META_WIDTH-1:0]  pif_meta_out,
   input  logic                   pif_valid_out,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [RANK_WIDTH-1:0]  m_rank,
   output logic [META_WIDTH-1:0]  m_meta,
   output logic [L2_MAX_SIZE-1:0] count,
   output logic                   full,
   output logic                   empty
);

   localparam logic [L2_MAX_SIZE-1:0] CAP = L2_MAX_SIZE'(capacity(MAX_SIZE));
   localparam logic [L2_MAX_SIZE-1:0] ONE = L2_MAX_SIZE'(1);

   pifo_state_e            state_reg, state_next;
   logic [L2_MAX_SIZE-1:0] count_reg, count_next;
   logic                   m_valid_reg, m_valid_next;
   logic [RANK_WIDTH-1:0]  m_rank_reg, m_rank_next;
   logic [META_WIDTH-1:0]  m_meta_reg, m_meta_next;

   logic full_int;
   logic empty_int;
   logic pop_go;
   logic ins_go;

   // The PIFO head is only trusted after a full cycle with no operation (STABLE).
   always_comb begin
      full_int  = (count_reg == CAP);
      empty_int = (count_reg == '0);
      pop_go    = !rst && (state_reg == ST_STABLE) && !empty_int && pif_valid_out &&
                  (!m_valid_reg || m_ready);
      ins_go    = s_valid && !full_int && !pop_go && !rst;
   end

   always_comb begin
      state_next = ST_STABLE;
      if (ins_go || pop_go) begin
         state_next = ST_WAIT;
      end
   end

   always_comb begin
      count_next   = count_reg;
      m_valid_next = m_valid_reg;
      m_rank_next  = m_rank_reg;
      m_meta_next  = m_meta_reg;
      if (ins_go) begin
         count_next = count_reg + ONE;
      end else if (pop_go) begin
         count_next = count_reg - ONE;
      end
      if (pop_go) begin
         m_valid_next = 1'b1;
         m_rank_next  = pif_rank_out;
         m_meta_next  = pif_meta_out;
      end else if (m_valid_reg && m_ready) begin
         m_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_WAIT;
         count_reg   <= '0;
         m_valid_reg <= 1'b0;
         m_rank_reg  <= '0;
         m_meta_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         m_valid_reg <= m_valid_next;
         m_rank_reg  <= m_rank_next;
         m_meta_reg  <= m_meta_next;
      end
   end

   assign s_ready     = !full_int && !pop_go && !rst;
   assign pif_insert  = ins_go;
   assign pif_remove  = pop_go;
   assign pif_rank_in = s_rank;
   assign pif_meta_in = s_meta;
   assign m_valid     = m_valid_reg;
   assign m_rank      = m_rank_reg;
   assign m_meta      = m_meta_reg;
   assign count       = count_reg;
   assign full        = full_int;
   assign empty       = empty_int;

endmodule
